// File: rtl/rggen_rtl_pkg.sv
// Shared types for rggen bit-field RTL: lock/enable qualifier modes and key-lock states.
package rggen_rtl_pkg;
  typedef enum logic {
    RGGEN_ENABLE_MODE = 1'b0,
    RGGEN_LOCK_MODE   = 1'b1
  } rggen_rwle_mode;

  typedef enum logic [1:0] {
    RGGEN_KEY_LOCKED,
    RGGEN_KEY_KEYING,
    RGGEN_KEY_UNLOCKED
  } rggen_key_lock_state;

  // Width helper that never collapses to zero bits.
  function automatic int rggen_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rggen_bit_field_if.sv
// Bit-field side of the register decoder: write strobe/data/mask in, read data and value out.
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             write_access;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output write_access, write_mask, write_data,
    input  read_data, value
  );

  modport slave (
    input  write_access, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_key_lock_fsm.sv
// Key-sequence lock: tracks progress through the key list and the unlock lifetime.
module rggen_key_lock_fsm
  import rggen_rtl_pkg::*;
#(
  parameter int KEY_COUNT = 2,
  parameter int TIMEOUT   = 0,
  parameter bit ONE_SHOT  = 1'b0
)(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 key_write,
  input  logic                                 key_match,
  input  logic                                 key_first_match,
  input  logic                                 data_write,
  input  logic                                 force_lock,
  output logic [rggen_clog2(KEY_COUNT)-1:0]    idx,
  output logic                                 unlocked
);
  localparam int IDX_W = rggen_clog2(KEY_COUNT);
  localparam int TMR_W = rggen_clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_COUNT - 1);

  rggen_key_lock_state state;
  logic [TMR_W-1:0]    timer;
  logic                expire;

  // timer == 1 is the final unlocked cycle, so the lifetime is exactly TIMEOUT.
  assign expire = ((TIMEOUT > 0) && (timer == TMR_W'(1))) || (ONE_SHOT && data_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RGGEN_KEY_LOCKED;
      idx      <= '0;
      timer    <= '0;
      unlocked <= 1'b0;
    end else if (force_lock || ((state == RGGEN_KEY_UNLOCKED) && (key_write || expire))) begin
      state    <= RGGEN_KEY_LOCKED;
      idx      <= '0;
      timer    <= '0;
      unlocked <= 1'b0;
    end else if (state == RGGEN_KEY_UNLOCKED) begin
      if (TIMEOUT > 0) timer <= timer - TMR_W'(1);
    end else if (key_write) begin
      if ((key_match && (idx == LAST_IDX)) || (!key_match && key_first_match && (KEY_COUNT == 1))) begin
        state    <= RGGEN_KEY_UNLOCKED;
        idx      <= '0;
        timer    <= TMR_W'(TIMEOUT);
        unlocked <= 1'b1;
      end else if (key_match) begin
        state <= RGGEN_KEY_KEYING;
        idx   <= idx + IDX_W'(1);
      end else if (key_first_match) begin
        // A wrong key that equals the first key restarts the sequence rather than aborting it.
        state <= RGGEN_KEY_KEYING;
        idx   <= IDX_W'(1);
      end else begin
        state <= RGGEN_KEY_LOCKED;
        idx   <= '0;
      end
    end
  end
endmodule

// File: rtl/rggen_bit_field_rwl_keyed.sv
// Read/write bit field whose writes are gated by a key-sequence unlock and the lock/enable qualifier.
module rggen_bit_field_rwl_keyed
  import rggen_rtl_pkg::*;
#(
  parameter rggen_rwle_mode             MODE             = RGGEN_LOCK_MODE,
  parameter int                         WIDTH            = 1,
  parameter logic [WIDTH-1:0]           INITIAL_VALUE    = '0,
  parameter int                         KEY_WIDTH        = 8,
  parameter int                         KEY_COUNT        = 2,
  parameter logic [KEY_WIDTH-1:0]       KEYS [KEY_COUNT] = '{8'h5A, 8'hA5},
  parameter int                         TIMEOUT          = 0,
  parameter bit                         ONE_SHOT         = 1'b0
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_lock_or_enable,
  input  logic              i_force_lock,
  rggen_bit_field_if.slave  bit_field_if,
  rggen_bit_field_if.slave  key_if,
  output logic [WIDTH-1:0]  o_value,
  output logic              o_unlocked
);
  localparam int IDX_W = rggen_clog2(KEY_COUNT);

  logic [IDX_W-1:0] key_idx;
  logic             key_write;
  logic             key_match;
  logic             key_first_match;
  logic             data_write;
  logic [WIDTH-1:0] value;

  assign key_write       = key_if.write_access;
  assign key_match       = (&key_if.write_mask) && (key_if.write_data == KEYS[key_idx]);
  assign key_first_match = key_if.write_data == KEYS[0];
  assign data_write      = o_unlocked && (i_lock_or_enable == MODE) && bit_field_if.write_access;

  rggen_key_lock_fsm #(
    .KEY_COUNT (KEY_COUNT),
    .TIMEOUT   (TIMEOUT),
    .ONE_SHOT  (ONE_SHOT)
  ) u_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_write       (key_write),
    .key_match       (key_match),
    .key_first_match (key_first_match),
    .data_write      (data_write),
    .force_lock      (i_force_lock),
    .idx             (key_idx),
    .unlocked        (o_unlocked)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INITIAL_VALUE;
    end else if (data_write) begin
      value <= (value & ~bit_field_if.write_mask) | (bit_field_if.write_data & bit_field_if.write_mask);
    end
  end

  assign o_value                = value;
  assign bit_field_if.read_data = value;
  assign bit_field_if.value     = value;
  // Only the lock status is visible; key values never read back.
  assign key_if.read_data       = KEY_WIDTH'(o_unlocked);
  assign key_if.value           = KEY_WIDTH'(o_unlocked);
endmodule

// File: tb/tb_rggen_bit_field_rwl_keyed.sv
// Bench: three variants (plain, TIMEOUT=4, ONE_SHOT) on shared stimulus, checked against a sequence model.
module tb_rggen_bit_field_rwl_keyed;
  import rggen_rtl_pkg::*;

  localparam int         N           = 3;
  localparam int         TO_P [N]    = '{0, 4, 0};
  localparam bit         OS_P [N]    = '{1'b0, 1'b0, 1'b1};
  localparam logic [7:0] INIT        = 8'h3C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lk_en, force_lk, kwr, dwr;
  logic [7:0] kdata, kmask, ddata, dmask;

  logic [7:0] o_val [N];
  logic       o_unl [N];
  logic [7:0] rd_val [N];
  logic [7:0] bf_val [N];
  logic [7:0] rd_key [N];

  int         n_cmp = 0;
  int         n_bad = 0;

  // Model: count of consecutive correct keys, unlocked flag, remaining lifetime, data value.
  int         m_prog [N];
  bit         m_unl  [N];
  int         m_left [N];
  logic [7:0] m_val  [N];
  logic [7:0] mk [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    rggen_bit_field_if #(.WIDTH(8)) bfi ();
    rggen_bit_field_if #(.WIDTH(8)) kfi ();
    assign bfi.write_access = dwr;
    assign bfi.write_data   = ddata;
    assign bfi.write_mask   = dmask;
    assign kfi.write_access = kwr;
    assign kfi.write_data   = kdata;
    assign kfi.write_mask   = kmask;

    rggen_bit_field_rwl_keyed #(
      .MODE          (RGGEN_LOCK_MODE),
      .WIDTH         (8),
      .INITIAL_VALUE (INIT),
      .TIMEOUT       (TO_P[k]),
      .ONE_SHOT      (OS_P[k])
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_lock_or_enable (lk_en),
      .i_force_lock     (force_lk),
      .bit_field_if     (bfi),
      .key_if           (kfi),
      .o_value          (o_val[k]),
      .o_unlocked       (o_unl[k])
    );
    assign rd_val[k] = bfi.read_data;
    assign bf_val[k] = bfi.value;
    assign rd_key[k] = kfi.read_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_prog[k] = 0; m_unl[k] = 0; m_left[k] = 0; m_val[k] = INIT;
    end
  endtask

  task automatic model_step();
    bit perm, full;
    if (!rst_n) begin
      model_reset();
      return;
    end
    full = (kmask == 8'hFF);
    for (int k = 0; k < N; k++) begin
      perm = m_unl[k] && lk_en && dwr;
      if (perm) m_val[k] = (m_val[k] & ~dmask) | (ddata & dmask);
      if (m_unl[k]) begin
        m_left[k]--;
        if (force_lk || kwr || (OS_P[k] && perm) || (TO_P[k] > 0 && m_left[k] == 0)) begin
          m_unl[k] = 0; m_prog[k] = 0;
        end
      end else if (force_lk) begin
        m_prog[k] = 0;
      end else if (kwr) begin
        if (full && kdata == mk[m_prog[k]]) m_prog[k]++;
        else if (kdata == mk[0])            m_prog[k] = 1;
        else                                m_prog[k] = 0;
        if (m_prog[k] == 2) begin
          m_unl[k] = 1; m_left[k] = TO_P[k]; m_prog[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("o_value[%0d]", k), o_val[k], m_val[k]);
      chk($sformatf("read_data[%0d]", k), rd_val[k], m_val[k]);
      chk($sformatf("bf_value[%0d]", k), bf_val[k], m_val[k]);
      chk($sformatf("o_unlocked[%0d]", k), o_unl[k], m_unl[k]);
      chk($sformatf("key_read[%0d]", k), rd_key[k], {7'd0, m_unl[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic key(input logic [7:0] d);
    kwr = 1'b1; kdata = d; kmask = 8'hFF;
    tick();
    kwr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    dwr = 1'b1; ddata = d; dmask = 8'hFF;
    tick();
    dwr = 1'b0;
  endtask

  initial begin
    mk[0] = 8'h5A; mk[1] = 8'hA5;
    kwr = 0; dwr = 0; force_lk = 0; lk_en = 1;
    kdata = 0; kmask = 8'hFF; ddata = 0; dmask = 8'hFF;
    model_reset();
    @(negedge clk);
    compare_all();
    for (int k = 0; k < N; k++) begin
      chk("rst_value", o_val[k], INIT);
      chk("rst_unlocked", o_unl[k], 0);
    end
    rst_n = 1'b1;

    // Basic unlock and write.
    key(8'h5A); key(8'hA5);
    for (int k = 0; k < N; k++) chk("unlock_after_keys", o_unl[k], 1);
    chk("key_read_unlocked", rd_key[0], 8'h01);
    wr(8'h0F);
    chk("write_0f", o_val[0], 8'h0F);
    chk("oneshot_first_write", o_val[2], 8'h0F);
    chk("oneshot_relocked", o_unl[2], 0);
    wr(8'h77);
    chk("write_77", o_val[0], 8'h77);
    chk("oneshot_second_dropped", o_val[2], 8'h0F);
    key(8'h11);
    chk("key_relock", o_unl[0], 0);

    // Broken sequence keeps the field locked.
    key(8'h5A); key(8'h11); key(8'hA5);
    chk("bad_seq_locked", o_unl[0], 0);
    wr(8'h12);
    chk("bad_seq_dropped", o_val[0], 8'h77);

    // Repeated first key restarts the sequence.
    key(8'h5A); key(8'h5A); key(8'hA5);
    chk("restart_unlock", o_unl[0], 1);
    key(8'h00);

    // Timeout lifetime of exactly four cycles.
    key(8'h5A); key(8'hA5);
    chk("timeout_c1", o_unl[1], 1);
    tick(); chk("timeout_c2", o_unl[1], 1);
    tick(); chk("timeout_c3", o_unl[1], 1);
    tick(); chk("timeout_c4", o_unl[1], 1);
    wr(8'h99);
    chk("timeout_last_write", o_val[1], 8'h99);
    chk("timeout_expired", o_unl[1], 0);
    wr(8'hAA);
    chk("timeout_late_dropped", o_val[1], 8'h99);
    chk("plain_still_open", o_val[0], 8'hAA);
    lk_en = 1'b0;
    wr(8'h55);
    chk("qualifier_dropped", o_val[0], 8'hAA);
    lk_en = 1'b1;

    // Forced relock mid-sequence.
    key(8'h00); key(8'h5A);
    force_lk = 1'b1; tick(); force_lk = 1'b0;
    key(8'hA5);
    chk("force_then_a5_locked", o_unl[0], 0);

    // Async reset mid-sequence.
    key(8'h5A);
    rst_n = 1'b0; model_reset();
    #2;
    chk("async_rst_value", o_val[0], INIT);
    chk("async_rst_unlocked", o_unl[0], 0);
    tick();
    rst_n = 1'b1;
    key(8'hA5);
    chk("rst_then_a5_locked", o_unl[0], 0);

    // Data and key in the same cycle while unlocked.
    key(8'h5A); key(8'hA5);
    kwr = 1; kdata = 8'h00; dwr = 1; ddata = 8'h42;
    tick(); kwr = 0; dwr = 0;
    chk("same_cycle_write", o_val[0], 8'h42);
    chk("same_cycle_relock", o_unl[0], 0);

    // Forced relock with a write.
    key(8'h5A); key(8'hA5);
    force_lk = 1; dwr = 1; ddata = 8'h24;
    tick(); force_lk = 0; dwr = 0;
    chk("force_write_kept", o_val[0], 8'h24);
    chk("force_write_locked", o_unl[0], 0);

    // Write alongside the final key is dropped.
    key(8'h5A);
    kwr = 1; kdata = 8'hA5; dwr = 1; ddata = 8'h81;
    tick(); kwr = 0; dwr = 0;
    chk("final_key_write_dropped", o_val[0], 8'h24);
    chk("final_key_unlocks", o_unl[0], 1);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      kwr = ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 3))
        0: kdata = 8'h5A;
        1: kdata = 8'hA5;
        2: kdata = 8'h11;
        default: kdata = 8'($urandom);
      endcase
      kmask    = ($urandom_range(0, 9) == 0) ? 8'h0F : 8'hFF;
      dwr      = 1'($urandom_range(0, 1));
      ddata    = 8'($urandom);
      dmask    = 8'($urandom);
      force_lk = ($urandom_range(0, 49) == 0);
      lk_en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      tick();
      rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
